// File: rtl/wt_dcache_shct_if.sv
`default_nettype none
// ============================================================================
// Module   : wt_dcache_shct_if
// Brief    : Lookup / prediction / training bundle between the dcache
//            replacement path and the signature history counter table.
// Revision : 1.0 - initial release
// ============================================================================
interface wt_dcache_shct_if #(
  parameter int unsigned SigWidth = 14,
  parameter int unsigned CtrWidth = 2
) ();

  logic                lkp_vld_i;
  logic [SigWidth-1:0] lkp_sig_i;
  logic                lkp_rdy_o;
  logic                pred_vld_o;
  logic [CtrWidth-1:0] pred_ctr_o;
  logic                pred_dist_o;
  logic                conflict_o;
  logic                upd_vld_i;
  logic [SigWidth-1:0] upd_sig_i;
  logic                upd_hit_i;
  logic                upd_rdy_o;

  // Requester side (replacement logic / miss path)
  modport master (
    output lkp_vld_i, lkp_sig_i, upd_vld_i, upd_sig_i, upd_hit_i,
    input  lkp_rdy_o, pred_vld_o, pred_ctr_o, pred_dist_o, conflict_o, upd_rdy_o
  );

  // Table side
  modport slave (
    input  lkp_vld_i, lkp_sig_i, upd_vld_i, upd_sig_i, upd_hit_i,
    output lkp_rdy_o, pred_vld_o, pred_ctr_o, pred_dist_o, conflict_o, upd_rdy_o
  );

endinterface
`default_nettype wire

// File: rtl/wt_dcache_shct.sv
`default_nettype none
// ============================================================================
// Module   : wt_dcache_shct
// Brief    : Signature history counter table for SHiP/SRRIP insertion.
//            Folded-signature index, saturating counters, one-cycle-late
//            prediction, same-cycle lookup/update collision flag and an
//            init sweep after reset or flush.
// Revision : 1.0 - initial release
// ============================================================================
module wt_dcache_shct #(
  parameter int unsigned SigWidth = 14,
  parameter int unsigned IdxWidth = 10,
  parameter int unsigned CtrWidth = 2,
  parameter int unsigned InitVal  = 1
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  input  wire logic          flush_i,
  output logic               busy_o,
  wt_dcache_shct_if.slave    bus
);

  localparam int unsigned         c_entries  = 1 << IdxWidth;
  localparam logic [CtrWidth-1:0] c_ctr_max  = '1;
  localparam logic [CtrWidth-1:0] c_init_val = CtrWidth'(InitVal);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] init_idx_q, init_idx_d;
  logic [CtrWidth-1:0] tbl_q [c_entries];

  logic                pred_vld_q;
  logic [CtrWidth-1:0] pred_ctr_q;
  logic                pred_dist_q;
  logic                conflict_q;

  logic [IdxWidth-1:0] w_lkp_idx;
  logic [IdxWidth-1:0] w_upd_idx;
  logic                w_rdy;
  logic                w_lkp_acc;
  logic                w_upd_acc;
  logic [CtrWidth-1:0] w_upd_cur;
  logic [CtrWidth-1:0] w_upd_nxt;
  logic [CtrWidth-1:0] w_lkp_cur;
  logic                w_we;
  logic [IdxWidth-1:0] w_waddr;
  logic [CtrWidth-1:0] w_wdata;

  // Index hash: fold the upper signature bits onto the low index bits
  if (SigWidth > IdxWidth) begin : g_hash_fold
    assign w_lkp_idx = bus.lkp_sig_i[IdxWidth-1:0] ^ IdxWidth'(bus.lkp_sig_i[SigWidth-1:IdxWidth]);
    assign w_upd_idx = bus.upd_sig_i[IdxWidth-1:0] ^ IdxWidth'(bus.upd_sig_i[SigWidth-1:IdxWidth]);
  end else begin : g_hash_direct
    assign w_lkp_idx = IdxWidth'(bus.lkp_sig_i);
    assign w_upd_idx = IdxWidth'(bus.upd_sig_i);
  end

  // Both request channels are accepted only in RUN and never while a
  // flush or reset is being presented, so no request races the sweep.
  assign w_rdy     = (state_q == ST_RUN) & ~flush_i & ~rst_i;
  assign w_lkp_acc = bus.lkp_vld_i & w_rdy;
  assign w_upd_acc = bus.upd_vld_i & w_rdy;

  assign w_lkp_cur = tbl_q[w_lkp_idx];
  assign w_upd_cur = tbl_q[w_upd_idx];

  // Saturating training step
  always_comb begin
    w_upd_nxt = w_upd_cur;
    if (bus.upd_hit_i) begin
      if (w_upd_cur != c_ctr_max) w_upd_nxt = w_upd_cur + CtrWidth'(1);
    end else begin
      if (w_upd_cur != '0) w_upd_nxt = w_upd_cur - CtrWidth'(1);
    end
  end

  // Next-state logic and single table write port (sweep or training)
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    w_we       = 1'b0;
    w_waddr    = w_upd_idx;
    w_wdata    = w_upd_nxt;
    case (state_q)
      ST_INIT: begin
        if (flush_i) begin
          init_idx_d = '0;
        end else begin
          w_we       = 1'b1;
          w_waddr    = init_idx_q;
          w_wdata    = c_init_val;
          init_idx_d = init_idx_q + IdxWidth'(1);
          if (init_idx_q == '1) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d    = ST_INIT;
          init_idx_d = '0;
        end else begin
          w_we = w_upd_acc;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_idx_d = '0;
      end
    endcase
    if (rst_i) w_we = 1'b0;
  end

  // State register and sweep pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Counter storage; contents are defined by the sweep, not by reset
  always_ff @(posedge clk_i) begin
    if (w_we) tbl_q[w_waddr] <= w_wdata;
  end

  // Prediction register: pre-update counter value plus collision flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_vld_q  <= 1'b0;
      pred_ctr_q  <= '0;
      pred_dist_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      pred_vld_q <= w_lkp_acc;
      if (w_lkp_acc) begin
        pred_ctr_q  <= w_lkp_cur;
        pred_dist_q <= (w_lkp_cur == '0);
        conflict_q  <= w_upd_acc & (w_upd_idx == w_lkp_idx);
      end
    end
  end

  assign busy_o          = (state_q == ST_INIT);
  assign bus.lkp_rdy_o   = w_rdy;
  assign bus.upd_rdy_o   = w_rdy;
  assign bus.pred_vld_o  = pred_vld_q;
  assign bus.pred_ctr_o  = pred_ctr_q;
  assign bus.pred_dist_o = pred_dist_q;
  assign bus.conflict_o  = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_wt_dcache_shct.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_dcache_shct
// Brief    : Directed bench for wt_dcache_shct with a table-level reference
//            model compared against the DUT on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wt_dcache_shct;

  logic clk;
  logic rst;
  logic flush;
  logic busy;

  int tests;
  int fails;

  wt_dcache_shct_if #(.SigWidth(14), .CtrWidth(2)) bus ();

  wt_dcache_shct #(
    .SigWidth(14), .IdxWidth(10), .CtrWidth(2), .InitVal(1)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .busy_o  (busy),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: whole table as integers, sweep as a remaining-cycle count
  int m_tbl [1024];
  int m_left;
  bit m_known;
  bit m_pv;
  int m_pc;
  bit m_pd;
  bit m_pconf;

  initial m_known = 1'b0;

  function automatic int hidx(input logic [13:0] s);
    int v;
    v = int'(s);
    return (v % 1024) ^ (v / 1024);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance on each rising edge
  always @(posedge clk) begin
    bit rdy, la, ua;
    int li, ui;
    if (rst) begin
      m_known = 1'b1;
      m_left  = 1024;
      m_pv = 1'b0; m_pc = 0; m_pd = 1'b0; m_pconf = 1'b0;
      for (int i = 0; i < 1024; i++) m_tbl[i] = 1;
    end else if (m_known) begin
      rdy = (m_left == 0) && !flush;
      la  = bus.lkp_vld_i && rdy;
      ua  = bus.upd_vld_i && rdy;
      li  = hidx(bus.lkp_sig_i);
      ui  = hidx(bus.upd_sig_i);
      m_pv = la;
      if (la) begin
        m_pc    = m_tbl[li];
        m_pd    = (m_pc == 0);
        m_pconf = ua && (li == ui);
      end
      if (ua) begin
        if (bus.upd_hit_i) m_tbl[ui] = (m_tbl[ui] >= 3) ? 3 : m_tbl[ui] + 1;
        else               m_tbl[ui] = (m_tbl[ui] <= 0) ? 0 : m_tbl[ui] - 1;
      end
      if (flush) begin
        m_left = 1024;
        for (int i = 0; i < 1024; i++) m_tbl[i] = 1;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
  end

  // Per-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (m_known) begin
      chk("lkp_rdy", {31'b0, bus.lkp_rdy_o}, {31'b0, (m_left == 0) && !flush && !rst});
      chk("upd_rdy", {31'b0, bus.upd_rdy_o}, {31'b0, (m_left == 0) && !flush && !rst});
      chk("busy",    {31'b0, busy},          {31'b0, m_left > 0});
      chk("pred_vld", {31'b0, bus.pred_vld_o}, {31'b0, m_pv});
      if (m_pv) begin
        chk("pred_ctr",  {30'b0, bus.pred_ctr_o},  m_pc);
        chk("pred_dist", {31'b0, bus.pred_dist_o}, {31'b0, m_pd});
        chk("conflict",  {31'b0, bus.conflict_o},  {31'b0, m_pconf});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.lkp_rdy_o && n < 2000) begin
      cyc();
      n++;
    end
    chk(name, n, 1024);
  endtask

  task automatic upd(input logic [13:0] sig, input logic hit);
    bus.upd_vld_i = 1'b1;
    bus.upd_sig_i = sig;
    bus.upd_hit_i = hit;
    cyc();
    bus.upd_vld_i = 1'b0;
  endtask

  task automatic lookup_chk(input string name, input logic [13:0] sig,
                            input int exp_ctr, input bit exp_dist, input bit exp_conf);
    bus.lkp_vld_i = 1'b1;
    bus.lkp_sig_i = sig;
    cyc();
    bus.lkp_vld_i = 1'b0;
    chk({name, "_vld"},  {31'b0, bus.pred_vld_o},  1);
    chk({name, "_ctr"},  {30'b0, bus.pred_ctr_o},  exp_ctr);
    chk({name, "_dist"}, {31'b0, bus.pred_dist_o}, {31'b0, exp_dist});
    chk({name, "_conf"}, {31'b0, bus.conflict_o},  {31'b0, exp_conf});
    chk({name, "_model"}, m_pc, exp_ctr);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    flush = 1'b0;
    bus.lkp_vld_i = 1'b0;
    bus.lkp_sig_i = '0;
    bus.upd_vld_i = 1'b0;
    bus.upd_sig_i = '0;
    bus.upd_hit_i = 1'b0;
    cyc();
    cyc();
    chk("reset_pred_vld", {31'b0, bus.pred_vld_o}, 0);
    chk("reset_pred_ctr", {30'b0, bus.pred_ctr_o}, 0);
    chk("reset_conflict", {31'b0, bus.conflict_o}, 0);
    rst = 1'b0;

    // 1: initial sweep length and init value
    wait_ready("init_sweep_len");
    lookup_chk("init_val", 14'h1234, 1, 1'b0, 1'b0);

    // 2: decrement saturates at zero
    upd(14'h0005, 1'b0);
    upd(14'h0005, 1'b0);
    lookup_chk("dec_sat", 14'h0005, 0, 1'b1, 1'b0);

    // 3: increment saturates at max
    repeat (4) upd(14'h0005, 1'b1);
    lookup_chk("inc_sat", 14'h0005, 3, 1'b0, 1'b0);

    // 4: aliasing lookup/update collision
    bus.lkp_vld_i = 1'b1;
    bus.lkp_sig_i = 14'h0405;
    bus.upd_vld_i = 1'b1;
    bus.upd_sig_i = 14'h0004;
    bus.upd_hit_i = 1'b1;
    cyc();
    bus.lkp_vld_i = 1'b0;
    bus.upd_vld_i = 1'b0;
    chk("coll_conf", {31'b0, bus.conflict_o}, 1);
    chk("coll_ctr",  {30'b0, bus.pred_ctr_o}, 1);
    lookup_chk("coll_after", 14'h0004, 2, 1'b0, 1'b0);

    // 5: flush wins over a concurrent lookup and rewrites the table
    upd(14'h0007, 1'b1);
    upd(14'h0007, 1'b1);
    lookup_chk("e7_set", 14'h0007, 3, 1'b0, 1'b0);
    flush = 1'b1;
    bus.lkp_vld_i = 1'b1;
    bus.lkp_sig_i = 14'h0007;
    #1;
    chk("flush_rdy", {31'b0, bus.lkp_rdy_o}, 0);
    cyc();
    flush = 1'b0;
    bus.lkp_vld_i = 1'b0;
    chk("flush_pred_vld", {31'b0, bus.pred_vld_o}, 0);
    wait_ready("flush_sweep_len");
    lookup_chk("flush_val", 14'h0007, 1, 1'b0, 1'b0);

    // 6a: reset in the middle of a sweep, with requests held throughout
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (500) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.lkp_vld_i = 1'b1;
    bus.lkp_sig_i = 14'h0007;
    bus.upd_vld_i = 1'b1;
    bus.upd_sig_i = 14'h0007;
    bus.upd_hit_i = 1'b1;
    wait_ready("rst_sweep_len");
    bus.lkp_vld_i = 1'b0;
    bus.upd_vld_i = 1'b0;
    lookup_chk("rst_val", 14'h0007, 1, 1'b0, 1'b0);

    // 6b: flush during the sweep restarts it
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (300) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    wait_ready("reflush_sweep_len");
    lookup_chk("reflush_val", 14'h2345, 1, 1'b0, 1'b0);

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
